// File: rtl/layer_code.sv
// NeoPixel (WS2812-class) single-wire NRZ encoder: streams 24-bit GRB words MSB first,
// using per-bit sampled phase widths, then holds the line low for a latch period.
module layer_code #(
  parameter int RST_CNT_W = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic [7:0]           t0h_cnt_in,
  input  logic [7:0]           t0l_cnt_in,
  input  logic [7:0]           t1h_cnt_in,
  input  logic [7:0]           t1l_cnt_in,
  input  logic [RST_CNT_W-1:0] rst_cnt_in,
  input  logic                 data_valid_in,
  input  logic [23:0]          data_in,
  input  logic                 data_last_in,
  output logic                 data_ready_out,
  output logic                 bit_code_out,
  output logic                 busy_out,
  output logic                 done_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HIGH  = 2'd1,
    ST_LOW   = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [23:0]            data_q, data_d;
  logic                   last_q, last_d;
  logic [4:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             ph_cnt_q, ph_cnt_d;
  logic [7:0]             low_cnt_q, low_cnt_d;
  logic [RST_CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
  logic                   bit_code_q, bit_code_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;

  logic final_low_s;
  logic ready_s;
  logic xfer_s;

  // High width for the bit about to be sent; low width is latched alongside it.
  function automatic logic [7:0] high_width(input logic bit_val, input logic [7:0] t0h,
                                            input logic [7:0] t1h);
    return bit_val ? t1h : t0h;
  endfunction

  function automatic logic [7:0] low_width(input logic bit_val, input logic [7:0] t0l,
                                           input logic [7:0] t1l);
    return bit_val ? t1l : t0l;
  endfunction

  assign final_low_s = (state_q == ST_LOW) && (ph_cnt_q == 8'd0);
  assign ready_s     = (state_q == ST_IDLE) ||
                       (final_low_s && (bit_idx_q == 5'd0) && !last_q);
  assign xfer_s      = data_valid_in && ready_s;

  // Next-state, counters and registered output values.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    last_d    = last_q;
    bit_idx_d = bit_idx_q;
    ph_cnt_d  = ph_cnt_q;
    low_cnt_d = low_cnt_q;
    lat_cnt_d = lat_cnt_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (xfer_s) begin
          state_d   = ST_HIGH;
          data_d    = data_in;
          last_d    = data_last_in;
          bit_idx_d = 5'd23;
          ph_cnt_d  = high_width(data_in[23], t0h_cnt_in, t1h_cnt_in);
          low_cnt_d = low_width(data_in[23], t0l_cnt_in, t1l_cnt_in);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HIGH: begin
        if (ph_cnt_q == 8'd0) begin
          state_d  = ST_LOW;
          ph_cnt_d = low_cnt_q;
        end else begin
          ph_cnt_d = ph_cnt_q - 8'd1;
        end
      end
      ST_LOW: begin
        if (ph_cnt_q != 8'd0) begin
          ph_cnt_d = ph_cnt_q - 8'd1;
        end else if (bit_idx_q != 5'd0) begin
          // The word shifts left so the bit on the wire is always data_q[23].
          state_d   = ST_HIGH;
          bit_idx_d = bit_idx_q - 5'd1;
          data_d    = {data_q[22:0], 1'b0};
          ph_cnt_d  = high_width(data_q[22], t0h_cnt_in, t1h_cnt_in);
          low_cnt_d = low_width(data_q[22], t0l_cnt_in, t1l_cnt_in);
        end else if (last_q) begin
          state_d   = ST_LATCH;
          lat_cnt_d = rst_cnt_in;
        end else if (xfer_s) begin
          state_d   = ST_HIGH;
          data_d    = data_in;
          last_d    = data_last_in;
          bit_idx_d = 5'd23;
          ph_cnt_d  = high_width(data_in[23], t0h_cnt_in, t1h_cnt_in);
          low_cnt_d = low_width(data_in[23], t0l_cnt_in, t1l_cnt_in);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LATCH: begin
        if (lat_cnt_q == {RST_CNT_W{1'b0}}) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          lat_cnt_d = lat_cnt_q - {{(RST_CNT_W-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    bit_code_d = (state_d == ST_HIGH);
    busy_d     = (state_d != ST_IDLE);
  end

  // State and datapath registers; reset forces the line low immediately.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= ST_IDLE;
      data_q     <= 24'd0;
      last_q     <= 1'b0;
      bit_idx_q  <= 5'd0;
      ph_cnt_q   <= 8'd0;
      low_cnt_q  <= 8'd0;
      lat_cnt_q  <= {RST_CNT_W{1'b0}};
      bit_code_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      last_q     <= last_d;
      bit_idx_q  <= bit_idx_d;
      ph_cnt_q   <= ph_cnt_d;
      low_cnt_q  <= low_cnt_d;
      lat_cnt_q  <= lat_cnt_d;
      bit_code_q <= bit_code_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign data_ready_out = ready_s;
  assign bit_code_out   = bit_code_q;
  assign busy_out       = busy_q;
  assign done_out       = done_q;

endmodule

// File: doc/layer_code.md
# layer_code

Serial line encoder for the NeoPixel (WS2812-class) output. It takes 24-bit GRB pixel words over a valid/ready stream and drives the single-wire NRZ waveform, MSB first. High and low phase widths come from the four timing counts produced by the layer timing-configuration register block. After the last pixel of a frame it holds the line low for a programmable latch/reset period.

## Interface
- `RST_CNT_W`, default 16: width of the latch-period count.
- `clk_in`, input, 1: system clock.
- `rst_in`, input, 1: reset, asynchronous, active-high.
- `t0h_cnt_in`, `t0l_cnt_in`, `t1h_cnt_in`, `t1l_cnt_in`, input, 8 each: phase widths from the config block.
- `rst_cnt_in`, input, RST_CNT_W: width of the latch period.
- `data_valid_in`, input, 1: a pixel word is offered.
- `data_in`, input, 24: pixel word; bit 23 is sent first.
- `data_last_in`, input, 1: the offered word is the last of its frame.
- `data_ready_out`, output, 1: the block accepts a word this cycle.
- `bit_code_out`, output, 1: encoded line output. Registered.
- `busy_out`, output, 1: high in every state except IDLE.
- `done_out`, output, 1: one-cycle pulse when the latch period ends.

## Operation
- A transfer occurs on any cycle with `data_valid_in & data_ready_out`. On that edge the block captures `data_in` and `data_last_in`, and the bit index loads 23.
- Phase length rule: a count of N gives N+1 cycles, so a count of 0 gives 1 cycle and 255 gives 256 cycles. The phase counter is 8 bits and counts down to 0.
- The four timing counts are sampled once per bit, on the edge that enters HIGH. Changes to them mid-bit have no effect until the next bit.
- Bit value 1 uses t1h/t1l. Bit value 0 uses t0h/t0l.
- States and transitions:
  - IDLE
    - `bit_code_out`=0, `data_ready_out`=1.
    - On a transfer, go to HIGH.
  - HIGH
    - `bit_code_out`=1, `data_ready_out`=0.
    - When the counter reaches 0, go to LOW.
  - LOW
    - `bit_code_out`=0.
    - Before the final cycle, `data_ready_out`=0.
    - Final cycle, bit index > 0: decrement the index and go to HIGH.
    - Final cycle of bit 0, captured last=0: `data_ready_out`=1. A transfer in this cycle goes to HIGH with no gap. With no transfer, go to IDLE; the line stays low (underrun, no error flag).
    - Final cycle of bit 0, captured last=1: `data_ready_out`=0, go to LATCH.
  - LATCH
    - `bit_code_out`=0, `data_ready_out`=0.
    - Lasts `rst_cnt_in`+1 cycles; `rst_cnt_in` is sampled on entry.
    - Then go to IDLE, with `done_out`=1 on the first IDLE cycle.
- `data_ready_out` is combinational from the state and counters. It does not depend on `data_valid_in`.

## Timing
- Reset values: state IDLE, `bit_code_out`=0, `busy_out`=0, `done_out`=0, all counters 0. Consequently `data_ready_out`=1 after reset.
- Reset asserted mid-bit or mid-latch: `bit_code_out` drops to 0 asynchronously. The pending pixel is discarded and `done_out` is not pulsed.
- Latency: transfer on edge k, then `bit_code_out` is 1 in the cycle after edge k. The first HIGH cycle is registered, not combinational.
- Bit period: (tXh+1) + (tXl+1) cycles exactly.
- Pixel period: the sum of its 24 bit periods, with no extra cycles between bits or between back-to-back pixels.
- Frame end: the LATCH period is `rst_cnt_in`+1 cycles, then `done_out` is a single-cycle pulse, concurrent with `data_ready_out`=1. A transfer in that same cycle is accepted normally.
- `data_valid_in` high while `data_ready_out`=0: no transfer. `data_in` is ignored, and the source must hold the word.
- `busy_out` is registered with the state and falls on the cycle `done_out` rises.

## Test plan
- Single-bit timing.
  - Setup: t0h=2, t0l=5, t1h=5, t1l=2, `rst_cnt_in`=9; send 0xA00000 with last=1.
  - Bits 23..20 must be 1,0,1,0: 6 high + 3 low for a 1, 3 high + 6 low for a 0.
  - Then 216 cycles of pixel, 10 low latch cycles, and `done_out` high for exactly one cycle.
- Back-to-back pixels.
  - Setup: valid held high, words 0xFFFFFF (last=0) then 0x000000 (last=1).
  - `data_ready_out` pulses only on the final LOW cycle of the first pixel.
  - The second pixel's first HIGH cycle immediately follows, with no gap.
  - Total time from first high to `done_out` is 432+10 cycles.
- Zero counts.
  - Setup: all four counts=0, `rst_cnt_in`=0.
  - Each bit is 1 high + 1 low cycle, and the latch is 1 cycle.
- Underrun.
  - Setup: send one word with last=0 and drop valid.
  - The block returns to IDLE with the line low and `done_out` never pulses.
  - A later word is accepted and encoded correctly.
- Mid-bit config change.
  - Change t1h from 5 to 1 during a HIGH phase.
  - The current bit keeps 6 high cycles; the next 1-bit has 2 high cycles.
- Reset mid-frame.
  - Assert `rst_in` during the HIGH phase of bit 12.
  - `bit_code_out` is 0 immediately, then IDLE with ready=1.
  - No `done_out` pulse, and the next frame encodes from bit 23.
